// File: rtl/sync_mesh_router.sv
// sync_mesh_router: single-flit mesh node. Each input has a small FIFO. The FIFO head
// is XY-routed, each output arbitrates round-robin among the heads aimed at it, and
// heads aimed at a disabled port are dropped and counted.
module sync_mesh_router #(
    parameter int         N       = 32,
    parameter int         XW      = 4,
    parameter int         YW      = 4,
    parameter int         SELF_X  = 0,
    parameter int         SELF_Y  = 0,
    parameter int         DEPTH   = 4,
    parameter logic [4:0] PORT_EN = 5'b11111
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [4:0]     in_valid,
    output logic [4:0]     in_ready,
    input  logic [5*N-1:0] in_data,
    output logic [4:0]     out_valid,
    input  logic [4:0]     out_ready,
    output logic [5*N-1:0] out_data,
    output logic           err_drop,
    output logic [15:0]    drop_cnt
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [XW-1:0] SX      = XW'(SELF_X);
    localparam logic [YW-1:0] SY      = YW'(SELF_Y);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    logic [N-1:0]  mem_q [5][DEPTH];
    logic [N-1:0]  mem_d [5][DEPTH];
    logic [AW-1:0] wr_ptr_q [5];
    logic [AW-1:0] wr_ptr_d [5];
    logic [AW-1:0] rd_ptr_q [5];
    logic [AW-1:0] rd_ptr_d [5];
    logic [AW:0]   cnt_q [5];
    logic [AW:0]   cnt_d [5];
    logic [2:0]    rr_q [5];
    logic [2:0]    rr_d [5];
    logic [4:0]    out_valid_q, out_valid_d;
    logic [N-1:0]  out_data_q [5];
    logic [N-1:0]  out_data_d [5];
    logic          err_drop_q, err_drop_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic [N-1:0]  head [5];
    logic [2:0]    route [5];
    logic [4:0]    nonempty, misroute, push, pop, gnt_vld;
    logic [2:0]    gnt_src [5];
    logic [3:0]    rr_sum;
    logic [2:0]    cand;
    logic [16:0]   drop_sum;

    // FIFO head XY route; a route onto a disabled port marks the head for dropping
    always_comb begin
        for (int p = 0; p < 5; p++) begin
            head[p]     = mem_q[p][rd_ptr_q[p]];
            nonempty[p] = (cnt_q[p] != '0);
            if (head[p][N-1 -: XW] > SX)         route[p] = 3'd2;
            else if (head[p][N-1 -: XW] < SX)    route[p] = 3'd4;
            else if (head[p][N-1-XW -: YW] > SY) route[p] = 3'd1;
            else if (head[p][N-1-XW -: YW] < SY) route[p] = 3'd3;
            else                                 route[p] = 3'd0;
            misroute[p] = nonempty[p] && !PORT_EN[route[p]];
        end
    end

    // Input acceptance depends only on occupancy, never on a same-cycle pop
    always_comb begin
        for (int p = 0; p < 5; p++) begin
            in_ready[p] = PORT_EN[p] && rst && (cnt_q[p] < DEPTH_C);
            push[p]     = in_valid[p] && in_ready[p];
        end
    end

    // Per-output round-robin search starting one past the last granted input
    always_comb begin
        gnt_vld = '0;
        pop     = misroute;
        rr_sum  = '0;
        cand    = '0;
        for (int o = 0; o < 5; o++) begin
            gnt_src[o] = 3'd0;
            if (PORT_EN[o] && (!out_valid_q[o] || out_ready[o])) begin
                for (int k = 1; k <= 5; k++) begin
                    rr_sum = {1'b0, rr_q[o]} + 4'(k);
                    cand   = (rr_sum >= 4'd5) ? 3'(rr_sum - 4'd5) : rr_sum[2:0];
                    if (!gnt_vld[o] && nonempty[cand] && route[cand] == 3'(o)) begin
                        gnt_vld[o] = 1'b1;
                        gnt_src[o] = cand;
                        pop[cand]  = 1'b1;
                    end
                end
            end
        end
    end

    // FIFO pointers, output registers and drop accounting for the next edge
    always_comb begin
        mem_d      = mem_q;
        err_drop_d = |misroute;
        drop_sum   = {1'b0, drop_cnt_q};
        for (int p = 0; p < 5; p++) begin
            wr_ptr_d[p] = wr_ptr_q[p] + AW'(push[p]);
            rd_ptr_d[p] = rd_ptr_q[p] + AW'(pop[p]);
            cnt_d[p]    = cnt_q[p] + (AW+1)'(push[p]) - (AW+1)'(pop[p]);
            if (push[p]) mem_d[p][wr_ptr_q[p]] = in_data[p*N +: N];
            drop_sum    = drop_sum + 17'(misroute[p]);
        end
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        for (int o = 0; o < 5; o++) begin
            out_valid_d[o] = out_valid_q[o];
            out_data_d[o]  = out_data_q[o];
            rr_d[o]        = rr_q[o];
            if (gnt_vld[o]) begin
                out_valid_d[o] = 1'b1;
                out_data_d[o]  = head[gnt_src[o]];
                rr_d[o]        = gnt_src[o];
            end else if (out_ready[o]) begin
                out_valid_d[o] = 1'b0;
            end
        end
    end

    // Control state with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < 5; p++) begin
                wr_ptr_q[p]   <= '0;
                rd_ptr_q[p]   <= '0;
                cnt_q[p]      <= '0;
                rr_q[p]       <= '0;
                out_data_q[p] <= '0;
            end
            out_valid_q <= '0;
            err_drop_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            for (int p = 0; p < 5; p++) begin
                wr_ptr_q[p]   <= wr_ptr_d[p];
                rd_ptr_q[p]   <= rd_ptr_d[p];
                cnt_q[p]      <= cnt_d[p];
                rr_q[p]       <= rr_d[p];
                out_data_q[p] <= out_data_d[p];
            end
            out_valid_q <= out_valid_d;
            err_drop_q  <= err_drop_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // FIFO storage needs no reset; occupancy alone decides what is live
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Disabled outputs are tied off
    always_comb begin
        out_data = '0;
        for (int o = 0; o < 5; o++) begin
            out_data[o*N +: N] = PORT_EN[o] ? out_data_q[o] : '0;
        end
    end

    assign out_valid = out_valid_q & PORT_EN;
    assign err_drop  = err_drop_q;
    assign drop_cnt  = drop_cnt_q;
endmodule
